bus_arbiter_n: RTL and testbench
================================

Name: bus_arbiter_n

Overview:
- Parametrised N-master, single-slave bus arbiter with registered grant.
- Generalises the fixed two-master (UART master over CPU) bus mux in the computer top.
- Adds selectable fixed or round-robin priority, a per-transaction hold until slave ack or master abort, and a timeout watchdog that returns an error ack when the slave never responds.
- Sits between the bus masters (CPU, UART master, future DMA/VGA) and the shared memory/IO bus.

Parameters:
- NUM_MASTERS, 3, number of masters, 2..8; index 0 is highest priority in fixed mode.
- ADDR_W, 16, address width.
- DAT_W, 8, data width.
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- TIMEOUT, 255, cycles in BUSY without ack before an error ack is forced; 0 disables the watchdog.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_m_cs  in  NUM_MASTERS  per-master request/chip select; held until acked.
- i_m_we  in  NUM_MASTERS  per-master write enable.
- i_m_addr  in  NUM_MASTERS*ADDR_W  flattened addresses; master k at [k*ADDR_W +: ADDR_W].
- i_m_dat  in  NUM_MASTERS*DAT_W  flattened write data, same packing.
- o_m_grant  out  NUM_MASTERS  one-hot registered grant.
- o_m_ack  out  NUM_MASTERS  per-master transfer-complete strobe.
- o_m_err  out  NUM_MASTERS  per-master timeout error strobe.
- o_m_dat  out  DAT_W  read data to all masters = i_s_dat, pass-through.
- o_s_addr  out  ADDR_W  slave address.
- o_s_dat  out  DAT_W  slave write data.
- o_s_we  out  1  slave write enable.
- o_s_cs  out  1  slave chip select.
- i_s_ack  in  1  slave ack, 1-cycle or level.
- i_s_dat  in  DAT_W  slave read data.

Behaviour:
- Reset values:
  - State IDLE; o_m_grant=0, o_m_ack=0, o_m_err=0.
  - o_s_cs=0, o_s_we=0, o_s_addr=0, o_s_dat=0.
  - last_grant index = NUM_MASTERS-1, so master 0 wins first in RR mode.
  - Timeout counter = 0.
- Reset mid-transaction: all of the above take effect at the next edge. No ack or err is issued for the killed transfer.
- Slave outputs:
  - o_s_addr/o_s_dat/o_s_we come from the granted master while in BUSY; they are 0 in IDLE.
  - o_s_cs = BUSY & i_m_cs[g], where g is the granted index.
- IDLE state:
  - If any i_m_cs is high, select a winner.
  - Fixed mode: lowest set index.
  - RR mode: first set index after last_grant, searching upward with wrap-around.
  - Next edge: o_m_grant[winner]=1, state BUSY, counter cleared.
  - Latency: request sampled at edge t, grant and o_s_cs visible after edge t+1.
- BUSY state:
  - o_m_ack[g] = i_s_ack & o_s_cs (combinational). o_m_ack is 0 for all other masters.
  - Counter increments each cycle without ack, saturating at TIMEOUT.
  - On i_s_ack & o_s_cs: next edge goes to IDLE, grant cleared, last_grant = g.
  - The IDLE cycle is a mandatory one-cycle turnaround, so the same master can be re-granted no earlier than 2 cycles after its ack.
- Abort: if i_m_cs[g] drops in BUSY without ack, next edge goes to IDLE, grant cleared, last_grant = g. No ack or err is issued.
- Timeout (TIMEOUT>0):
  - When the counter reaches TIMEOUT with no ack in that cycle, o_m_ack[g]=1 and o_m_err[g]=1 for exactly that cycle.
  - o_s_cs is forced 0 in that cycle.
  - Next edge goes to IDLE, last_grant = g.
- Simultaneous ack and timeout in the same cycle: ack wins; o_m_err stays 0.
- Requests arriving while BUSY are ignored until IDLE. Arbitration uses the i_m_cs value sampled in IDLE only.
- Counter width is $clog2(TIMEOUT+1), minimum 1.
- Invariant: o_m_grant is one-hot or zero at all times.

Test Plan:
- Fixed mode, i_m_cs=3'b110 held from cycle 0, slave acks 2 cycles after o_s_cs:
  - Master 1 granted at cycle 1 and acked.
  - IDLE for 1 cycle, then master 1 re-granted.
  - Master 2 starves while master 1 keeps requesting.
- ROUND_ROBIN=1, all three masters request continuously, slave acks immediately: grant sequence is 0,1,2,0,1,2, each separated by one IDLE cycle.
- Master 0 writes addr 16'h1234, dat 8'hA5:
  - o_s_addr=16'h1234, o_s_dat=8'hA5, o_s_we=1 while granted.
  - Slave returns i_s_dat=8'h5A on a read; o_m_dat=8'h5A in the ack cycle.
- TIMEOUT=4, slave never acks:
  - o_m_ack[0] and o_m_err[0] both high for one cycle, 4 cycles after the grant.
  - o_s_cs low in that cycle; IDLE next cycle.
- TIMEOUT=4, slave acks exactly in the timeout cycle: o_m_ack=1, o_m_err=0.
- i_reset pulsed one cycle while BUSY with master 2: o_m_grant=0, o_s_cs=0 after the edge; no ack or err; in RR mode master 0 wins next.

Source files
------------

// File: rtl/bus_arbiter_n.sv
// N-master, single-slave bus arbiter: registered one-hot grant, fixed or round-robin
// priority, hold until slave ack or master abort, and a timeout watchdog error ack.
module bus_arbiter_n #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 16,
  parameter int DAT_W       = 8,
  parameter int ROUND_ROBIN = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_MASTERS-1:0]        i_m_cs,
  input  logic [NUM_MASTERS-1:0]        i_m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr,
  input  logic [NUM_MASTERS*DAT_W-1:0]  i_m_dat,
  output logic [NUM_MASTERS-1:0]        o_m_grant,
  output logic [NUM_MASTERS-1:0]        o_m_ack,
  output logic [NUM_MASTERS-1:0]        o_m_err,
  output logic [DAT_W-1:0]              o_m_dat,
  output logic [ADDR_W-1:0]             o_s_addr,
  output logic [DAT_W-1:0]              o_s_dat,
  output logic                          o_s_we,
  output logic                          o_s_cs,
  input  logic                          i_s_ack,
  input  logic [DAT_W-1:0]              i_s_dat
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0]       gidx_reg, gidx_next;
  logic [IDX_W-1:0]       last_reg, last_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;

  logic [ADDR_W-1:0] m_addr [NUM_MASTERS];
  logic [DAT_W-1:0]  m_dat  [NUM_MASTERS];

  logic [IDX_W-1:0] fixed_idx;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] win_idx;
  logic             any_req;
  logic             busy;
  logic             cur_cs;
  logic             cs_raw;
  logic             ack_raw;
  logic             timeout_hit;
  logic             end_strobe;
  logic             err_strobe;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign m_addr[gi] = i_m_addr[gi*ADDR_W +: ADDR_W];
      assign m_dat[gi]  = i_m_dat[gi*DAT_W +: DAT_W];
    end
  endgenerate

  // Fixed priority: scan from the top down so the lowest requesting index is kept.
  always_comb begin
    fixed_idx = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (i_m_cs[k[IDX_W-1:0]]) begin
        fixed_idx = k[IDX_W-1:0];
      end
    end
  end

  // Round-robin: offsets are scanned from farthest to nearest so the first set
  // index after last_reg wins; last_reg itself is the lowest-priority candidate.
  always_comb begin
    int cand;
    rr_idx = '0;
    cand   = 0;
    for (int off = NUM_MASTERS; off >= 1; off--) begin
      cand = int'(last_reg) + off;
      if (cand >= NUM_MASTERS) begin
        cand = cand - NUM_MASTERS;
      end
      if (i_m_cs[cand[IDX_W-1:0]]) begin
        rr_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign any_req = |i_m_cs;
  assign win_idx = (ROUND_ROBIN != 0) ? rr_idx : fixed_idx;

  assign busy    = (state_reg == ST_BUSY);
  assign cur_cs  = i_m_cs[gidx_reg];
  assign cs_raw  = busy & cur_cs;
  assign ack_raw = cs_raw & i_s_ack;

  // A real slave ack in the watchdog cycle takes precedence over the error.
  generate
    if (TIMEOUT > 0) begin : g_wdog
      assign timeout_hit = cs_raw & ~i_s_ack & (cnt_reg == CNT_MAX);
    end else begin : g_no_wdog
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // A transfer killed by reset must not report completion.
  assign end_strobe = (ack_raw | timeout_hit) & ~i_reset;
  assign err_strobe = timeout_hit & ~i_reset;

  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_strobe
      assign o_m_ack[gi] = grant_reg[gi] & end_strobe;
      assign o_m_err[gi] = grant_reg[gi] & err_strobe;
    end
  endgenerate

  assign o_m_grant = grant_reg;
  assign o_m_dat   = i_s_dat;
  assign o_s_cs    = cs_raw & ~timeout_hit;
  assign o_s_addr  = busy ? m_addr[gidx_reg] : '0;
  assign o_s_dat   = busy ? m_dat[gidx_reg] : '0;
  assign o_s_we    = busy & i_m_we[gidx_reg];

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    gidx_next  = gidx_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          state_next          = ST_BUSY;
          grant_next          = '0;
          grant_next[win_idx] = 1'b1;
          gidx_next           = win_idx;
          cnt_next            = '0;
        end
      end
      ST_BUSY: begin
        // Ack, abort and timeout all release the bus through one IDLE turnaround.
        if (ack_raw || timeout_hit || !cur_cs) begin
          state_next = ST_IDLE;
          grant_next = '0;
          last_next  = gidx_reg;
          cnt_next   = '0;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      gidx_reg  <= '0;
      last_reg  <= LAST_RST;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      gidx_reg  <= gidx_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Randomized scoreboard bench for bus_arbiter_n: a fixed-priority and a round-robin
// instance, each driven by its own masters/slave and checked against a reference model.
module tb_bus_arbiter_n;

  localparam int N      = 3;
  localparam int AW     = 16;
  localparam int DW     = 8;
  localparam int TO     = 4;
  localparam int PH0    = 40;
  localparam int CYCLES = 1500;

  typedef struct {
    int           unit;
    int           cyc;
    logic [N-1:0] grant;
    logic [N-1:0] ack;
    logic [N-1:0] err;
    logic         scs;
    logic         swe;
    logic [AW-1:0] saddr;
    logic [DW-1:0] sdat;
    logic [DW-1:0] mdat;
  } exp_t;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit 0: fixed priority. Unit 1: round-robin. Both TIMEOUT=4.
  logic            rst    [2];
  logic [N-1:0]    m_cs   [2];
  logic [N-1:0]    m_we   [2];
  logic [N*AW-1:0] m_addr [2];
  logic [N*DW-1:0] m_dat  [2];
  logic            s_ack  [2];
  logic [DW-1:0]   s_dat  [2];

  logic [N-1:0]  grant_o [2];
  logic [N-1:0]  ack_o   [2];
  logic [N-1:0]  err_o   [2];
  logic [DW-1:0] mdat_o  [2];
  logic [AW-1:0] saddr_o [2];
  logic [DW-1:0] sdat_o  [2];
  logic          swe_o   [2];
  logic          scs_o   [2];

  bus_arbiter_n #(.NUM_MASTERS(N), .ADDR_W(AW), .DAT_W(DW), .ROUND_ROBIN(0), .TIMEOUT(TO)) u_fixed (
    .i_clk(clk), .i_reset(rst[0]), .i_m_cs(m_cs[0]), .i_m_we(m_we[0]),
    .i_m_addr(m_addr[0]), .i_m_dat(m_dat[0]), .o_m_grant(grant_o[0]), .o_m_ack(ack_o[0]),
    .o_m_err(err_o[0]), .o_m_dat(mdat_o[0]), .o_s_addr(saddr_o[0]), .o_s_dat(sdat_o[0]),
    .o_s_we(swe_o[0]), .o_s_cs(scs_o[0]), .i_s_ack(s_ack[0]), .i_s_dat(s_dat[0])
  );

  bus_arbiter_n #(.NUM_MASTERS(N), .ADDR_W(AW), .DAT_W(DW), .ROUND_ROBIN(1), .TIMEOUT(TO)) u_rr (
    .i_clk(clk), .i_reset(rst[1]), .i_m_cs(m_cs[1]), .i_m_we(m_we[1]),
    .i_m_addr(m_addr[1]), .i_m_dat(m_dat[1]), .o_m_grant(grant_o[1]), .o_m_ack(ack_o[1]),
    .o_m_err(err_o[1]), .o_m_dat(mdat_o[1]), .o_s_addr(saddr_o[1]), .o_s_dat(sdat_o[1]),
    .o_s_we(swe_o[1]), .o_s_cs(scs_o[1]), .i_s_ack(s_ack[1]), .i_s_dat(s_dat[1])
  );

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_rec = 0;
  int   cyc   = 0;
  int   exp_acks = 0, exp_errs = 0, dut_acks = 0, dut_errs = 0;

  // Reference model state: who owns the bus, since which cycle, who was served last.
  bit   busy  [2];
  int   owner [2];
  int   gcyc  [2];
  int   last  [2];
  bit   dead  [2];
  bit   clr   [2][N];

  task automatic chk(input string nm, input int u, input int c,
                     input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s unit%0d cyc%0d: got %h, expected %h", nm, u, c, act, req);
    end
  endtask

  function automatic int pick(input int u, input logic [N-1:0] req);
    if (u == 0) begin
      for (int k = 0; k < N; k++) if (req[k]) return k;
    end else begin
      for (int j = 1; j <= N; j++) begin
        int c;
        c = (last[u] + j) % N;
        if (req[c]) return c;
      end
    end
    return -1;
  endfunction

  task automatic step(input int u);
    exp_t e;
    bit   ph0, cs_raw, acked, to;
    int   o;
    ph0 = (cyc < PH0);
    for (int k = 0; k < N; k++) begin
      if (clr[u][k]) m_cs[u][k] = 1'b0;
      clr[u][k] = 1'b0;
      if (!m_cs[u][k] && (ph0 || ($urandom % 2 == 0))) begin
        m_cs[u][k]            = 1'b1;
        m_we[u][k]            = 1'($urandom);
        m_addr[u][k*AW +: AW] = AW'($urandom);
        m_dat[u][k*DW +: DW]  = DW'($urandom);
      end
    end
    if (!ph0 && ($urandom % 25 == 0)) dead[u] = !dead[u];
    rst[u]   = !ph0 && busy[u] && ($urandom % 150 == 0);
    s_ack[u] = ph0 ? 1'b1 : (!dead[u] && ($urandom % 3 == 0));
    s_dat[u] = DW'($urandom);
    o = owner[u];
    if (!ph0 && busy[u] && ($urandom % 40 == 0)) m_cs[u][o] = 1'b0;

    cs_raw = busy[u] && m_cs[u][o];
    acked  = cs_raw && s_ack[u];
    to     = cs_raw && !s_ack[u] && (cyc - gcyc[u] == TO);

    e.unit  = u;
    e.cyc   = cyc;
    e.grant = '0;
    e.ack   = '0;
    e.err   = '0;
    if (busy[u]) e.grant[o] = 1'b1;
    e.scs   = cs_raw && !to;
    e.saddr = busy[u] ? m_addr[u][o*AW +: AW] : '0;
    e.sdat  = busy[u] ? m_dat[u][o*DW +: DW] : '0;
    e.swe   = busy[u] ? m_we[u][o] : 1'b0;
    e.mdat  = s_dat[u];
    if (!rst[u] && (acked || to)) begin
      e.ack[o] = 1'b1;
      e.err[o] = to;
      exp_acks++;
      if (to) exp_errs++;
    end
    q.push_back(e);

    if (rst[u]) begin
      busy[u] = 1'b0;
      last[u] = N - 1;
    end else if (busy[u]) begin
      if (acked || to || !cs_raw) begin
        busy[u] = 1'b0;
        last[u] = o;
        if (acked || to) clr[u][o] = 1'b1;
      end
    end else begin
      int w;
      w = pick(u, m_cs[u]);
      if (w >= 0) begin
        busy[u]  = 1'b1;
        owner[u] = w;
        gcyc[u]  = cyc + 1;
      end
    end
  endtask

  // Monitor: pops each expected cycle response and compares it to the DUT.
  initial begin
    exp_t e;
    int   u;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        u = e.unit;
        n_rec++;
        chk("grant", u, e.cyc, 32'(grant_o[u]), 32'(e.grant));
        chk("grant_onehot", u, e.cyc, 32'($onehot0(grant_o[u])), 32'd1);
        chk("ack", u, e.cyc, 32'(ack_o[u]), 32'(e.ack));
        chk("err", u, e.cyc, 32'(err_o[u]), 32'(e.err));
        chk("s_cs", u, e.cyc, 32'(scs_o[u]), 32'(e.scs));
        chk("s_addr", u, e.cyc, 32'(saddr_o[u]), 32'(e.saddr));
        chk("s_dat", u, e.cyc, 32'(sdat_o[u]), 32'(e.sdat));
        chk("s_we", u, e.cyc, 32'(swe_o[u]), 32'(e.swe));
        chk("m_dat", u, e.cyc, 32'(mdat_o[u]), 32'(e.mdat));
        if (ack_o[u] != '0) dut_acks++;
        if (err_o[u] != '0) dut_errs++;
        if (e.ack != '0)
          $display("txn unit%0d cyc%0d master_mask=%b err=%b addr=%h we=%b wdat=%h rdat=%h",
                   u, e.cyc, e.ack, (e.err != '0), e.saddr, e.swe, e.sdat, e.mdat);
      end
    end
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u]    = 1'b1;
      m_cs[u]   = '0;
      m_we[u]   = '0;
      m_addr[u] = '0;
      m_dat[u]  = '0;
      s_ack[u]  = 1'b0;
      s_dat[u]  = '0;
      busy[u]   = 1'b0;
      owner[u]  = 0;
      gcyc[u]   = 0;
      last[u]   = N - 1;
      dead[u]   = 1'b0;
      for (int k = 0; k < N; k++) clr[u][k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < PH0 + CYCLES; i++) begin
      step(0);
      step(1);
      cyc++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    chk("queue_drained", 0, cyc, 32'(q.size()), 32'd0);
    chk("records", 0, cyc, 32'(n_rec), 32'(2 * cyc));
    chk("ack_count", 0, cyc, 32'(dut_acks), 32'(exp_acks));
    chk("err_count", 0, cyc, 32'(dut_errs), 32'(exp_errs));
    chk("timeouts_exercised", 0, cyc, 32'(exp_errs > 0), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
